column_sweep_scheduler: RTL
===========================

// Module: column_sweep_scheduler
// PURPOSE
//  Sequences the array of build_column instances through the heat-diffusion solve.
//  - Issues the shared start strobe.
//  - Waits until every column has acknowledged and completed one row update.
//  - Counts rows per sweep and sweeps per frame.
//  - Pauses on a frame boundary so the VGA readout can sample a stable grid.
// PARAMETERS
//  NUM_COLS   64    number of build_column instances driven by start
//  ROW_W      8     width of height / row_idx (matches column row_bits+1)
//  ITER_W     16    width of iter_limit / iter_cnt
//  INIT_PAD   8     extra cycles added to the column init wait
//  TMO_CYC    64    watchdog limit, in cycles, for the WAIT_ACK and WAIT_DONE states
// PORTS
//  clk          in   1          system clock (CLOCK_50 at top level)
//  reset        in   1          synchronous, active-high
//  run          in   1          level enable; 0 parks the scheduler in READY
//  height       in   ROW_W      index of the top row (column holds height+1 rows)
//  iter_limit   in   ITER_W     sweeps per frame; 0 is treated as 1
//  col_flag     in   NUM_COLS   per-column flag (low = row in progress, high = row done)
//  frame_ack    in   1          pulse from the VGA readout: frame consumed, resume
//  start        out  1          shared start to all columns
//  row_idx      out  ROW_W      row currently being updated by every column
//  iter_cnt     out  ITER_W     sweeps completed in the current frame
//  frame_done   out  1          high while holding at a frame boundary
//  busy         out  1          high from ISSUE through ADVANCE
//  timeout_err  out  1          sticky; set when the watchdog expires
// BEHAVIOUR
//  Reset
//   - All outputs 0; state INIT; init counter 0.
//   - height and iter_limit are latched in INIT and held until the next reset.
//  INIT
//   - Count 2*(height+1)+INIT_PAD cycles, covering the column M10K zero-fill, then go to READY.
//   - start stays 0 throughout.
//  READY
//   - run=1: go to ISSUE.
//   - Otherwise hold. start stays 0.
//  ISSUE
//   - Drive start=1 and go to WAIT_ACK.
//  WAIT_ACK
//   - Hold start=1 until every bit of col_flag is 0 (all columns have left their wait state).
//   - In that cycle, deassert start (registered, so start is 0 the following cycle) and go to WAIT_DONE.
//   - start must never be high while any column could re-enter its wait state; worst-case
//     hold is 1 cycle beyond the acknowledge.
//  WAIT_DONE
//   - Wait until col_flag is all 1s, then go to ADVANCE.
//  ADVANCE (1 cycle)
//   - row_idx == latched height: row_idx <= 0 and iter_cnt <= iter_cnt+1.
//   - Otherwise row_idx <= row_idx+1.
//   - If iter_cnt+1 == max(iter_limit,1) at wrap: go to FRAME_HOLD.
//   - Otherwise go to READY.
//  FRAME_HOLD
//   - frame_done=1.
//   - On frame_ack: iter_cnt <= 0, frame_done <= 0, go to READY.
//   - frame_ack outside FRAME_HOLD is ignored.
//  Watchdog
//   - Counter clears on every state entry and increments in WAIT_ACK and WAIT_DONE.
//   - At TMO_CYC: set timeout_err, drop start, go to ERROR.
//   - ERROR holds until reset.
//  Boundary and simultaneous-event rules
//   - run dropping mid-row does not abort: the current row completes and the scheduler then parks in READY.
//   - reset mid-row returns to INIT. The columns also reset, so re-initialisation is consistent.
//   - Reset has priority over every other event.
//   - height=0: every ADVANCE wraps; one row per sweep.
//   - Widths: counters wrap modulo 2^ROW_W / 2^ITER_W. Comparisons are unsigned.
// STRUCTURE
//  - Shared package: state encoding localparams (INIT, READY, ISSUE, WAIT_ACK, WAIT_DONE,
//    ADVANCE, FRAME_HOLD, ERROR) and ROW_W/ITER_W defaults, shared with the top level.
//  - One sub-module: flag_reduce, a registered AND/NOR reduction of col_flag producing
//    all_done and all_ack, one cycle of latency. Both are timing-critical at NUM_COLS=64.
//  - Everything else is a single FSM with its counters.
// TESTING
//  1. Reset, height=3.
//     -> start first rises exactly 2*4+8 cycles after reset falls, plus the ISSUE cycle.
//  2. Column models acknowledge 2 cycles after start and complete 6 cycles later; height=3, iter_limit=2.
//     -> row_idx runs 0,1,2,3,0,1,2,3.
//     -> frame_done rises after the 8th ADVANCE with iter_cnt=2.
//     -> frame_ack returns iter_cnt to 0 and restarts rows.
//  3. One column (bit 17) acknowledges 5 cycles late.
//     -> start stays high until that acknowledge.
//     -> ADVANCE waits for bit 17 to complete.
//     -> No second start within the row.
//  4. run dropped mid-WAIT_DONE.
//     -> The row completes and row_idx increments once.
//     -> start stays 0 while run=0.
//  5. Column bit 0 never completes.
//     -> timeout_err=1 exactly TMO_CYC cycles after WAIT_DONE entry.
//     -> start=0.
//     -> Only reset clears the error.
//  6. reset asserted during WAIT_ACK with start=1.
//     -> start=0 the next cycle.
//     -> row_idx=0, iter_cnt=0; state INIT.

Source files
------------

// File: rtl/column_sweep_scheduler_pkg.sv
// Shared definitions for the column sweep scheduler: FSM state encoding and
// default widths used by the scheduler, its interface and the top level.
package column_sweep_scheduler_pkg;

   localparam int NUM_COLS_DEF = 64;
   localparam int ROW_W_DEF    = 8;
   localparam int ITER_W_DEF   = 16;

   typedef enum logic [2:0] {
      ST_INIT       = 3'd0,
      ST_READY      = 3'd1,
      ST_ISSUE      = 3'd2,
      ST_WAIT_ACK   = 3'd3,
      ST_WAIT_DONE  = 3'd4,
      ST_ADVANCE    = 3'd5,
      ST_FRAME_HOLD = 3'd6,
      ST_ERROR      = 3'd7
   } sched_state_t;

endpackage

// File: rtl/column_sweep_scheduler_if.sv
// Bundle between the scheduler, the build_column array and the VGA readout.
// master = scheduler side, slave = environment (columns, readout, control).
interface column_sweep_scheduler_if
   import column_sweep_scheduler_pkg::*;
#(
   parameter int NUM_COLS = NUM_COLS_DEF,
   parameter int ROW_W    = ROW_W_DEF,
   parameter int ITER_W   = ITER_W_DEF
) ();

   logic                run;
   logic [ROW_W-1:0]    height;
   logic [ITER_W-1:0]   iter_limit;
   logic [NUM_COLS-1:0] col_flag;
   logic                frame_ack;
   logic                start;
   logic [ROW_W-1:0]    row_idx;
   logic [ITER_W-1:0]   iter_cnt;
   logic                frame_done;
   logic                busy;
   logic                timeout_err;

   modport master (
      input  run, height, iter_limit, col_flag, frame_ack,
      output start, row_idx, iter_cnt, frame_done, busy, timeout_err
   );

   modport slave (
      output run, height, iter_limit, col_flag, frame_ack,
      input  start, row_idx, iter_cnt, frame_done, busy, timeout_err
   );

endinterface

// File: rtl/column_sweep_scheduler_flag_reduce.sv
// Registered wide reduction of the per-column flags. all_done means every
// column has finished its row, all_ack means every column has left its wait
// state. Both carry one cycle of latency to keep the 64-input trees off the
// FSM's critical path.
module column_sweep_scheduler_flag_reduce #(
   parameter int NUM_COLS = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_COLS-1:0] col_flag,
   output logic                all_done,
   output logic                all_ack
);

   logic all_done_reg;
   logic all_ack_reg;

   // Register the AND / NOR reductions of the flag vector.
   always_ff @(posedge clk) begin
      if (reset) begin
         all_done_reg <= 1'b0;
         all_ack_reg  <= 1'b0;
      end else begin
         all_done_reg <= &col_flag;
         all_ack_reg  <= ~|col_flag;
      end
   end

   assign all_done = all_done_reg;
   assign all_ack  = all_ack_reg;

endmodule

// File: rtl/column_sweep_scheduler.sv
// Sequences the build_column array through the heat-diffusion solve: waits
// out the column zero-fill, issues the shared start per row, waits for all
// columns to acknowledge and complete, counts rows/sweeps and holds at each
// frame boundary until the VGA readout has consumed the grid.
module column_sweep_scheduler
   import column_sweep_scheduler_pkg::*;
#(
   parameter int NUM_COLS = NUM_COLS_DEF,
   parameter int ROW_W    = ROW_W_DEF,
   parameter int ITER_W   = ITER_W_DEF,
   parameter int INIT_PAD = 8,
   parameter int TMO_CYC  = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   column_sweep_scheduler_if.master  bus
);

   // Init count reaches 2*(2^ROW_W)+INIT_PAD at most; three extra bits cover it.
   localparam int CNT_W = ROW_W + 3;
   localparam int WD_W  = $clog2(TMO_CYC) + 1;

   sched_state_t      state_reg;
   logic [CNT_W-1:0]  init_cnt_reg;
   logic [WD_W-1:0]   wd_cnt_reg;
   logic [ROW_W-1:0]  height_reg;
   logic [ITER_W-1:0] iter_limit_reg;
   logic [ROW_W-1:0]  row_idx_reg;
   logic [ITER_W-1:0] iter_cnt_reg;
   logic              start_reg;
   logic              frame_done_reg;
   logic              busy_reg;
   logic              timeout_err_reg;

   logic              all_done;
   logic              all_ack;
   logic [CNT_W-1:0]  init_last;
   logic [ITER_W-1:0] iter_inc;
   logic [ITER_W-1:0] iter_target;
   logic              wd_expired;

   column_sweep_scheduler_flag_reduce #(
      .NUM_COLS (NUM_COLS)
   ) u_flag_reduce (
      .clk      (clk),
      .reset    (reset),
      .col_flag (bus.col_flag),
      .all_done (all_done),
      .all_ack  (all_ack)
   );

   // Last init count value: 2*(height+1)+INIT_PAD cycles in total.
   assign init_last   = CNT_W'({bus.height, 1'b0}) + CNT_W'(INIT_PAD + 1);
   assign iter_inc    = iter_cnt_reg + ITER_W'(1);
   // An iteration limit of zero behaves as one sweep per frame.
   assign iter_target = (iter_limit_reg == '0) ? ITER_W'(1) : iter_limit_reg;
   assign wd_expired  = (wd_cnt_reg == WD_W'(TMO_CYC - 1));

   // Scheduler FSM with its counters and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= ST_INIT;
         init_cnt_reg    <= '0;
         wd_cnt_reg      <= '0;
         height_reg      <= '0;
         iter_limit_reg  <= '0;
         row_idx_reg     <= '0;
         iter_cnt_reg    <= '0;
         start_reg       <= 1'b0;
         frame_done_reg  <= 1'b0;
         busy_reg        <= 1'b0;
         timeout_err_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_INIT: begin
               height_reg     <= bus.height;
               iter_limit_reg <= bus.iter_limit;
               if (init_cnt_reg == init_last) begin
                  init_cnt_reg <= '0;
                  state_reg    <= ST_READY;
               end else begin
                  init_cnt_reg <= init_cnt_reg + CNT_W'(1);
               end
            end
            ST_READY: begin
               if (bus.run) begin
                  start_reg <= 1'b1;
                  busy_reg  <= 1'b1;
                  state_reg <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               wd_cnt_reg <= '0;
               state_reg  <= ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
               if (all_ack) begin
                  start_reg  <= 1'b0;
                  wd_cnt_reg <= '0;
                  state_reg  <= ST_WAIT_DONE;
               end else if (wd_expired) begin
                  start_reg       <= 1'b0;
                  busy_reg        <= 1'b0;
                  timeout_err_reg <= 1'b1;
                  state_reg       <= ST_ERROR;
               end else begin
                  wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
               end
            end
            ST_WAIT_DONE: begin
               if (all_done) begin
                  wd_cnt_reg <= '0;
                  state_reg  <= ST_ADVANCE;
               end else if (wd_expired) begin
                  busy_reg        <= 1'b0;
                  timeout_err_reg <= 1'b1;
                  state_reg       <= ST_ERROR;
               end else begin
                  wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
               end
            end
            ST_ADVANCE: begin
               busy_reg <= 1'b0;
               if (row_idx_reg == height_reg) begin
                  row_idx_reg  <= '0;
                  iter_cnt_reg <= iter_inc;
                  if (iter_inc == iter_target) begin
                     frame_done_reg <= 1'b1;
                     state_reg      <= ST_FRAME_HOLD;
                  end else begin
                     state_reg <= ST_READY;
                  end
               end else begin
                  row_idx_reg <= row_idx_reg + ROW_W'(1);
                  state_reg   <= ST_READY;
               end
            end
            ST_FRAME_HOLD: begin
               if (bus.frame_ack) begin
                  iter_cnt_reg   <= '0;
                  frame_done_reg <= 1'b0;
                  state_reg      <= ST_READY;
               end
            end
            ST_ERROR: begin
               state_reg <= ST_ERROR;
            end
            default: begin
               state_reg <= ST_INIT;
            end
         endcase
      end
   end

   assign bus.start       = start_reg;
   assign bus.row_idx     = row_idx_reg;
   assign bus.iter_cnt    = iter_cnt_reg;
   assign bus.frame_done  = frame_done_reg;
   assign bus.busy        = busy_reg;
   assign bus.timeout_err = timeout_err_reg;

endmodule
